// File: rtl/polyshift_r_seq.sv
// polyshift_r_seq: bit-serial right shifter with carry and zero flags.
// It moves one bit position per clock in one of four modes: logical,
// arithmetic, rotate, or rotate through carry. Requests arrive over a
// valid/ready handshake. The result is held in dedicated output registers,
// so data_o/cf_o/zf_o keep the last result until the next one is produced.
// WORD_WIDTH must be at least 2.
module polyshift_r_seq #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WORD_WIDTH-1:0]         data_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
  input  logic [1:0]                    mode_i,
  input  logic                          cf_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WORD_WIDTH-1:0]         data_o,
  output logic                          cf_o,
  output logic                          zf_o
);

  localparam int CntWidth = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_ROR = 2'b10,
    MODE_RCR = 2'b11
  } shiftMode_e;

  state_e                  state_q, state_d;
  shiftMode_e              mode_q, mode_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    carry_q, carry_d;
  logic [CntWidth-1:0]     shiftCnt_q, shiftCnt_d;
  logic [WORD_WIDTH-1:0]   result_q;
  logic                    resultCf_q;
  logic                    resultZf_q;

  logic [WORD_WIDTH-1:0]   stepData;
  logic                    stepCarry;
  logic                    loadResult;

  // Compute one 1-bit right step of the working word. Only the bit that
  // enters the MSB depends on the mode. The bit leaving bit 0 always becomes
  // the carry, so rotate-through-carry forms a (W+1)-bit ring with carry_q.
  always_comb begin
    stepData  = {1'b0, data_q[WORD_WIDTH-1:1]};
    stepCarry = data_q[0];
    unique case (mode_q)
      MODE_LSR: stepData[WORD_WIDTH-1] = 1'b0;
      MODE_ASR: stepData[WORD_WIDTH-1] = data_q[WORD_WIDTH-1];
      MODE_ROR: stepData[WORD_WIDTH-1] = data_q[0];
      MODE_RCR: stepData[WORD_WIDTH-1] = carry_q;
      default:  stepData[WORD_WIDTH-1] = 1'b0;
    endcase
  end

  // Next-state and working-register update logic. A request is only taken
  // in IDLE, and ready_o is exactly the IDLE decode, so valid_i alone
  // qualifies the accept. loadResult marks the edge that produces a result:
  // either a zero-length accept or the final shift step.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_d     = data_q;
    carry_d    = carry_q;
    shiftCnt_d = shiftCnt_q;
    loadResult = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d     = data_i;
          carry_d    = cf_i;
          mode_d     = shiftMode_e'(mode_i);
          shiftCnt_d = shift_size_i;
          if (shift_size_i == '0) begin
            state_d    = DONE;
            loadResult = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d     = stepData;
        carry_d    = stepCarry;
        shiftCnt_d = shiftCnt_q - CntWidth'(1);
        if (shiftCnt_q == CntWidth'(1)) begin
          state_d    = DONE;
          loadResult = 1'b1;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers. Reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= MODE_LSR;
      data_q     <= '0;
      carry_q    <= 1'b0;
      shiftCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      carry_q    <= carry_d;
      shiftCnt_q <= shiftCnt_d;
    end
  end

  // Result registers. They capture the final working value on the edge
  // that enters DONE and then hold it until the next result is produced.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q   <= '0;
      resultCf_q <= 1'b0;
      resultZf_q <= 1'b1;
    end else if (loadResult) begin
      result_q   <= data_d;
      resultCf_q <= carry_d;
      resultZf_q <= (data_d == '0);
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign data_o  = result_q;
  assign cf_o    = resultCf_q;
  assign zf_o    = resultZf_q;

endmodule

// File: tb/tb_polyshift_r_seq.sv
// Directed testbench for polyshift_r_seq (WORD_WIDTH = 8). It uses a table
// of hand-computed vectors plus hand-written back-pressure and reset
// sequences.
module tb_polyshift_r_seq;

  localparam int W        = 8;
  localparam int MaxWait  = 40;
  localparam int NumVecs  = 14;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   n;
    logic [1:0]   mode;
    logic         cf;
    logic [W-1:0] expData;
    logic         expCf;
    logic         expZf;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic [2:0]   shift_size_i;
  logic [1:0]   mode_i;
  logic         cf_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         cf_o;
  logic         zf_o;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t vecs [NumVecs];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  polyshift_r_seq #(.WORD_WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .shift_size_i (shift_size_i),
    .mode_i       (mode_i),
    .cf_i         (cf_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .cf_o         (cf_o),
    .zf_o         (zf_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (at negedges) for valid_o. cycles is counted from the accept edge.
  task automatic waitValid(input string name, inout int cycles, output bit seen);
    while (!valid_o && cycles < MaxWait) begin
      @(negedge clk);
      cycles++;
    end
    seen = valid_o;
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_timeout: got valid_o=0 after %0d cycles, expected 1", name, cycles);
    end
  endtask

  // Issues one request from a negedge with ready_i high. It scrambles the
  // inputs after the accept edge, checks the result and latency, and then
  // completes the handshake.
  task automatic applyStimulus(input vec_t v);
    int cycles;
    bit seen;
    checkOutput({v.name, "_ready_idle"}, 32'(ready_o), 32'd1);
    data_i       = v.data;
    shift_size_i = v.n;
    mode_i       = v.mode;
    cf_i         = v.cf;
    valid_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i      = 1'b0;
    data_i       = ~v.data;
    shift_size_i = ~v.n;
    mode_i       = ~v.mode;
    cf_i         = ~v.cf;
    checkOutput({v.name, "_ready_busy"}, 32'(ready_o), 32'd0);
    cycles = 1;
    waitValid(v.name, cycles, seen);
    if (seen) begin
      checkOutput({v.name, "_latency"}, 32'(cycles), 32'(v.n) + 32'd1);
      checkOutput({v.name, "_data"}, 32'(data_o), 32'(v.expData));
      checkOutput({v.name, "_cf"}, 32'(cf_o), 32'(v.expCf));
      checkOutput({v.name, "_zf"}, 32'(zf_o), 32'(v.expZf));
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, "_valid_drop"}, 32'(valid_o), 32'd0);
    checkOutput({v.name, "_ready_back"}, 32'(ready_o), 32'd1);
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int cycles;
    bit seen;
    vec_t v;

    vecs[0]  = '{8'hB5, 3'd3, 2'b00, 1'b0, 8'h16, 1'b1, 1'b0, "lsr_b5"};
    vecs[1]  = '{8'h96, 3'd2, 2'b01, 1'b0, 8'hE5, 1'b1, 1'b0, "asr_96"};
    vecs[2]  = '{8'h81, 3'd1, 2'b10, 1'b0, 8'hC0, 1'b1, 1'b0, "ror_81"};
    vecs[3]  = '{8'h01, 3'd7, 2'b10, 1'b0, 8'h02, 1'b0, 1'b0, "ror_01"};
    vecs[4]  = '{8'h02, 3'd2, 2'b11, 1'b1, 8'h40, 1'b1, 1'b0, "rcr_02"};
    vecs[5]  = '{8'hFF, 3'd7, 2'b00, 1'b0, 8'h01, 1'b1, 1'b0, "lsr_ff"};
    vecs[6]  = '{8'h80, 3'd7, 2'b01, 1'b1, 8'hFF, 1'b0, 1'b0, "asr_80"};
    vecs[7]  = '{8'h7F, 3'd7, 2'b01, 1'b0, 8'h00, 1'b1, 1'b1, "asr_7f"};
    vecs[8]  = '{8'h01, 3'd1, 2'b11, 1'b0, 8'h00, 1'b1, 1'b1, "rcr_01"};
    vecs[9]  = '{8'h00, 3'd7, 2'b11, 1'b1, 8'h02, 1'b0, 1'b0, "rcr_00"};
    vecs[10] = '{8'h00, 3'd0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1, "n0_rcr"};
    vecs[11] = '{8'h5A, 3'd0, 2'b01, 1'b1, 8'h5A, 1'b1, 1'b0, "n0_asr"};
    vecs[12] = '{8'h3C, 3'd0, 2'b10, 1'b0, 8'h3C, 1'b0, 1'b0, "n0_ror"};
    vecs[13] = '{8'h5A, 3'd4, 2'b00, 1'b1, 8'h05, 1'b1, 1'b0, "lsr_5a"};

    rst          = 1'b1;
    valid_i      = 1'b0;
    ready_i      = 1'b1;
    data_i       = '0;
    shift_size_i = '0;
    mode_i       = 2'b00;
    cf_i         = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_data", 32'(data_o), 32'd0);
    checkOutput("rst_cf", 32'(cf_o), 32'd0);
    checkOutput("rst_zf", 32'(zf_o), 32'd1);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset in the middle of a SHIFT. The previous result
    // (0x05, cf=1, zf=0) differs from the reset values in every flag.
    data_i       = 8'hFF;
    shift_size_i = 3'd7;
    mode_i       = 2'b00;
    cf_i         = 1'b0;
    valid_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_ready", 32'(ready_o), 32'd1);
    checkOutput("arst_valid", 32'(valid_o), 32'd0);
    checkOutput("arst_data", 32'(data_o), 32'd0);
    checkOutput("arst_cf", 32'(cf_o), 32'd0);
    checkOutput("arst_zf", 32'(zf_o), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    v = '{8'h80, 3'd7, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0, "post_rst"};
    applyStimulus(v);

    // Zero shift with back-pressure, then a request held across the
    // handshake edge.
    ready_i      = 1'b0;
    data_i       = 8'h5A;
    shift_size_i = 3'd0;
    mode_i       = 2'b00;
    cf_i         = 1'b1;
    valid_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'h00;
    cf_i    = 1'b0;
    checkOutput("bp_valid_c1", 32'(valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold_valid", 32'(valid_o), 32'd1);
      checkOutput("bp_hold_ready", 32'(ready_o), 32'd0);
      checkOutput("bp_hold_data", 32'(data_o), 32'h5A);
      checkOutput("bp_hold_cf", 32'(cf_o), 32'd1);
      checkOutput("bp_hold_zf", 32'(zf_o), 32'd0);
      @(negedge clk);
    end
    ready_i      = 1'b1;
    data_i       = 8'h01;
    shift_size_i = 3'd1;
    mode_i       = 2'b00;
    cf_i         = 1'b0;
    valid_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_idle_ready", 32'(ready_o), 32'd1);
    checkOutput("bp_idle_valid", 32'(valid_o), 32'd0);
    checkOutput("bp_idle_keep_data", 32'(data_o), 32'h5A);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 8'hFF;
    checkOutput("bp_next_busy", 32'(ready_o), 32'd0);
    cycles = 1;
    waitValid("bp_next", cycles, seen);
    if (seen) begin
      checkOutput("bp_next_latency", 32'(cycles), 32'd2);
      checkOutput("bp_next_data", 32'(data_o), 32'h00);
      checkOutput("bp_next_cf", 32'(cf_o), 32'd1);
      checkOutput("bp_next_zf", 32'(zf_o), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_next_ready_back", 32'(ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/polyshift_r_seq.md
# polyshift_r_seq

Multi-cycle right shifter with carry flag: accepts a word, a shift amount and a mode through a valid/ready handshake. It shifts the word right one bit position per clock and returns the result with its carry and zero flags. It complements the combinational polyshift family in std/utils/shifts as the small-area right-direction unit for datapaths that can tolerate variable latency.

## Interface
- WORD_WIDTH, 8, data width in bits; must be at least 2.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  block can accept a request; high only in IDLE.
- data_i  input  WORD_WIDTH  operand.
- shift_size_i  input  $clog2(WORD_WIDTH)  shift amount n, 0..WORD_WIDTH-1.
- mode_i  input  2  shift mode:
  - 00: logical (fill 0).
  - 01: arithmetic (fill MSB).
  - 10: rotate.
  - 11: rotate through carry.
- cf_i  input  1  incoming carry flag.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- data_o  output  WORD_WIDTH  shifted word.
- cf_o  output  1  carry flag after shift.
- zf_o  output  1  high when data_o == 0.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- Reset sets state to IDLE.
  - Output reset values: ready_o=1, valid_o=0, data_o=0, cf_o=0, zf_o=1.
  - Internal counter resets to 0.
- IDLE: a request is accepted when valid_i & ready_o at a rising edge (never while rst_i is high).
  - On accept, the block loads data_i into the data register, cf_i into the carry register, and latches mode_i and the counter (cnt = shift_size_i).
  - If n == 0, next state is DONE; otherwise next state is SHIFT.
- SHIFT: each edge performs one 1-bit right step and decrements cnt. When cnt == 1 at the edge, next state is DONE.
- Step rules (d = data register, c = carry register):
  - Logical: d = {0, d[W-1:1]}; c = d[0].
  - Arithmetic: d = {d[W-1], d[W-1:1]}; c = d[0].
  - Rotate: d = {d[0], d[W-1:1]}; c = d[0].
  - Rotate through carry: d = {c, d[W-1:1]}; c = d[0]. This is a (W+1)-bit ring.
- Result: for n > 0, cf_o equals the last bit shifted out. For n == 0, cf_o = cf_i and data_o = data_i unchanged, in all modes.
- DONE: valid_o=1; data_o, cf_o and zf_o are held stable.
  - While ready_i=0, all outputs stay frozen.
  - valid_o & ready_i at an edge moves the FSM to IDLE.
- data_o, cf_o and zf_o are registered. They keep the last result after DONE until the next result is produced; they are meaningful only while valid_o=1.
- Inputs other than valid_i are ignored outside the accept edge. Changing data_i mid-operation has no effect.
- mode_i and the carry are latched at accept. The result depends only on values captured at that edge.

## Timing
- Accept edge is cycle 0. valid_o rises after edge n, so it is visible in cycle n+1 (n=0 gives cycle 1).
- Latency is n+1 cycles. Minimum request-to-request spacing is n+2 cycles, with ready_i held high.
- ready_o falls in the cycle after the accept edge and rises in the cycle after the DONE handshake edge. There is no accept in the same cycle as the DONE handshake.
- Asserting rst_i at any point, including mid-SHIFT or in DONE with ready_i low, immediately forces the reset values with no clock needed.
  - The in-flight operation is discarded.
  - The first accept is possible at the first edge after rst_i deasserts.
- valid_o must not glitch: it is a registered state decode.

## Test plan
- Logical (W=8): data 0xB5, n=3, mode 00, cf_i=0.
  - Result: data_o=0x16, cf_o=1, zf_o=0.
  - valid_o appears in cycle 4.
- Arithmetic: data 0x96, n=2, mode 01 -> data_o=0xE5, cf_o=1.
- Rotate: data 0x81, n=1, mode 10 -> data_o=0xC0, cf_o=1. Second case: data 0x01, n=7, mode 10 -> data_o=0x02, cf_o=0.
- Rotate through carry: cf_i=1, data 0x02, n=2, mode 11.
  - Intermediate step gives 0x81/c=0.
  - Final: data_o=0x40, cf_o=1.
- Zero shift and back-pressure: data 0x5A, n=0, cf_i=1.
  - valid_o in cycle 1 with 0x5A, cf_o=1.
  - Hold ready_i=0 for 5 cycles: outputs are frozen and ready_o=0.
  - Then ready_i=1: IDLE next cycle, ready_o=1. A concurrent new request is accepted at the following edge.
  - Logical 0x01, n=1 -> data_o=0x00, zf_o=1, cf_o=1.
- Reset mid-operation: start 0xFF, n=7, mode 00, and pulse rst_i asynchronously between edges during SHIFT.
  - All outputs reach reset values before the next edge, with valid_o=0 and ready_o=1.
  - A new request 0x80, n=7 completes correctly with 0x01, cf_o=0.
